alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_decode.sv | 33 +++
 rtl/alu_exec.sv | 150 +++++++++++++++
 tb/tb_alu_exec.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Purpose: shared encodings for the ALU execute slice (control codes, ALUOp, FSM states).
// Latency: n/a, types, constants and one combinational helper only.
// Backpressure: n/a.
package alu_pkg;

  // 4-bit ALU control; the R-type codes are literally {funct7, funct3}
  typedef enum logic [3:0] {
    CTRL_ADD  = 4'b0000,
    CTRL_SLL  = 4'b0001,
    CTRL_SLT  = 4'b0010,
    CTRL_SLTU = 4'b0011,
    CTRL_XOR  = 4'b0100,
    CTRL_SRL  = 4'b0101,
    CTRL_OR   = 4'b0110,
    CTRL_AND  = 4'b0111,
    CTRL_SUB  = 4'b1000,
    CTRL_SRA  = 4'b1101,
    CTRL_MUL  = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_EXT    = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  // True when an R-type {funct7,funct3} pair names a supported operation
  function automatic logic is_rtype_code(input logic [3:0] code);
    case (code)
      CTRL_ADD, CTRL_SUB, CTRL_AND, CTRL_OR, CTRL_XOR,
      CTRL_SLL, CTRL_SRL, CTRL_SRA, CTRL_SLT, CTRL_SLTU: is_rtype_code = 1'b1;
      default:                                          is_rtype_code = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Purpose: map ALUOp/funct3/funct7 to the 4-bit ALU control (MUL decode under ALU_MUL_EN).
// Latency: purely combinational.
// Backpressure: none, no state and no handshake.
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7,
  output logic [3:0] alu_ctrl
);

  logic [3:0] rcode;
  assign rcode = {funct7, funct3};

  // Select control code; unknown R-type pairs and plain extended ops fall back to ADD
  always_comb begin
    alu_ctrl = CTRL_ADD;
    case (ALUOp)
      ALUOP_MEM:    alu_ctrl = CTRL_ADD;
      ALUOP_BRANCH: alu_ctrl = CTRL_SUB;
      ALUOP_RTYPE:  alu_ctrl = is_rtype_code(rcode) ? rcode : CTRL_ADD;
      ALUOP_EXT: begin
        alu_ctrl = CTRL_ADD;
`ifdef ALU_MUL_EN
        if (funct3 == 3'b000) alu_ctrl = CTRL_MUL;
`endif
      end
      default:      alu_ctrl = CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Purpose: ALU execute stage with valid/ready on both sides; optional iterative MUL (ALU_MUL_EN).
// Latency: single-cycle ops 1 cycle accept->out_valid; MUL XLEN+1 cycles; 1 op/cycle sustained.
// Backpressure: result held in HOLD until out_ready; in_ready follows out_ready in HOLD, low in BUSY.
module alu_exec
  import alu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctrl
);

  logic [3:0]      dec_ctrl;
  logic [XLEN-1:0] alu_res;
  logic [CNT_W-1:0] shamt;
  logic            accept;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [3:0]      ctrl_q, ctrl_d;
`ifdef ALU_MUL_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
`endif

  alu_decode u_decode (
    .ALUOp    (ALUOp),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (dec_ctrl)
  );

  assign shamt = op_b[CNT_W-1:0];

  // Single-cycle datapath on the live request operands
  always_comb begin
    alu_res = op_a + op_b;
    case (dec_ctrl)
      CTRL_SUB:  alu_res = op_a - op_b;
      CTRL_AND:  alu_res = op_a & op_b;
      CTRL_OR:   alu_res = op_a | op_b;
      CTRL_XOR:  alu_res = op_a ^ op_b;
      CTRL_SLL:  alu_res = op_a << shamt;
      CTRL_SRL:  alu_res = op_a >> shamt;
      CTRL_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      CTRL_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      CTRL_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:   alu_res = op_a + op_b;
    endcase
  end

  // Handshake outputs; in_ready is forced low while reset is held
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_HOLD: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    if (reset) in_ready = 1'b0;
  end

  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_HOLD);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign alu_ctrl  = ctrl_q;

  // Next-state: capture on accept, drain HOLD on out_ready, step the shift-add multiplier in BUSY
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ctrl_d   = ctrl_q;
`ifdef ALU_MUL_EN
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (state_q == ST_HOLD && out_ready) state_d = ST_IDLE;
        if (accept) begin
          ctrl_d   = dec_ctrl;
          state_d  = ST_HOLD;
          result_d = alu_res;
`ifdef ALU_MUL_EN
          if (dec_ctrl == CTRL_MUL) begin
            state_d  = ST_BUSY;
            result_d = '0;
            mcand_d  = op_a;
            mplier_d = op_b;
            cnt_d    = '0;
          end
`endif
        end
      end
      ST_BUSY: begin
`ifdef ALU_MUL_EN
        // result_q doubles as the accumulator; out_valid is low so nobody observes it
        if (mplier_q[0]) result_d = result_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_HOLD;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      ctrl_q   <= CTRL_ADD;
`ifdef ALU_MUL_EN
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ctrl_q   <= ctrl_d;
`ifdef ALU_MUL_EN
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Purpose: directed self-checking bench for alu_exec (XLEN=64); MUL scenarios under ALU_MUL_EN.
// Latency: checks 1-cycle ops and XLEN+1-cycle MUL.
// Backpressure: exercises out_ready stalls and back-to-back issue.
module tb_alu_exec;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic            funct7;
  logic [XLEN-1:0] op_a, op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [3:0]      alu_ctrl;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  ctrl;
  } vec_t;

  always #5 clk = ~clk;

  alu_exec #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUOp     (ALUOp),
    .funct3    (funct3),
    .funct7    (funct7),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .alu_ctrl  (alu_ctrl)
  );

  // Count delivered results
  always @(posedge clk) if (!reset && out_valid && out_ready) hs_cnt++;

  task automatic drive(input vec_t v);
    ALUOp = v.op; funct3 = v.f3; funct7 = v.f7; op_a = v.a; op_b = v.b;
    in_valid = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALUOp = 2'b00; funct3 = 3'b000; funct7 = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (alu_ctrl !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", alu_ctrl); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_alu_ops;
    vec_t v [11];
    v[0]  = '{2'b10, 3'b000, 1'b1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
    v[1]  = '{2'b01, 3'b000, 1'b0, 64'h1234, 64'h1234, 64'h0, 4'b1000};
    v[2]  = '{2'b11, 3'b001, 1'b0, 64'd3, 64'd4, 64'd7, 4'b0000};
    v[3]  = '{2'b00, 3'b111, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 4'b0000};
    v[4]  = '{2'b10, 3'b001, 1'b0, 64'd1, 64'h43, 64'd8, 4'b0001};
    v[5]  = '{2'b10, 3'b101, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 4'b0101};
    v[6]  = '{2'b10, 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 4'b0010};
    v[7]  = '{2'b10, 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0011};
    v[8]  = '{2'b10, 3'b001, 1'b1, 64'd2, 64'd3, 64'd5, 4'b0000};
    v[9]  = '{2'b10, 3'b000, 1'b0, 64'd10, 64'd20, 64'd30, 4'b0000};
`ifdef ALU_MUL_EN
    v[10] = '{2'b11, 3'b000, 1'b0, 64'd0, 64'd9, 64'd0, 4'b1111};
`else
    v[10] = '{2'b11, 3'b000, 1'b0, 64'd3, 64'd4, 64'd7, 4'b0000};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
`ifdef ALU_MUL_EN
      if (i == 10) continue;
`endif
      drive(v[i]);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL op%0d_in_ready: got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL op%0d_out_valid: got %b want 1", i, out_valid); end
      checks++; if (result !== v[i].res) begin errors++; $display("FAIL op%0d_result: got %h want %h", i, result, v[i].res); end
      checks++; if (alu_ctrl !== v[i].ctrl) begin errors++; $display("FAIL op%0d_ctrl: got %b want %b", i, alu_ctrl, v[i].ctrl); end
      checks++; if (zero !== (v[i].res == 64'd0)) begin errors++; $display("FAIL op%0d_zero: got %b want %b", i, zero, (v[i].res == 64'd0)); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL op%0d_drain: out_valid %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back;
    vec_t v [4];
    int h0;
    v[0] = '{2'b10, 3'b111, 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 4'b0111};
    v[1] = '{2'b10, 3'b110, 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hFFF0_FFF0_FFF0_FFF0, 4'b0110};
    v[2] = '{2'b10, 3'b101, 1'b1, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 4'b1101};
    v[3] = '{2'b10, 3'b011, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0011};
    out_ready = 1'b1;
    h0 = hs_cnt;
    for (int i = 0; i < 4; i++) begin
      drive(v[i]);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_in_ready: got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || result !== v[i].res) begin
        errors++; $display("FAIL b2b%0d_result: valid %b result %h want 1 %h", i, out_valid, result, v[i].res);
      end
      checks++; if (alu_ctrl !== v[i].ctrl) begin errors++; $display("FAIL b2b%0d_ctrl: got %b want %b", i, alu_ctrl, v[i].ctrl); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: out_valid %b want 0", out_valid); end
    checks++; if (hs_cnt - h0 !== 4) begin errors++; $display("FAIL b2b_handshakes: got %0d want 4", hs_cnt - h0); end
  endtask

  task automatic test_stall;
    vec_t vx, vn;
    int h0;
    vx = '{2'b10, 3'b100, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_0000_FFFF_0000, 64'h5555_AAAA_5555_AAAA, 4'b0100};
    vn = '{2'b10, 3'b000, 1'b1, 64'd1, 64'd1, 64'd0, 4'b1000};
    out_ready = 1'b0;
    drive(vx);
    @(posedge clk); #1;
    drive(vn);   // must be ignored while the XOR result is held
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || result !== vx.res || alu_ctrl !== vx.ctrl || zero !== 1'b0) begin
        errors++; $display("FAIL stall%0d_hold: valid %b result %h ctrl %b want 1 %h %b", i, out_valid, result, alu_ctrl, vx.res, vx.ctrl);
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall%0d_in_ready: got %b want 0", i, in_ready); end
      @(posedge clk); #1;
    end
    h0 = hs_cnt;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (hs_cnt - h0 !== 1) begin errors++; $display("FAIL stall_release_hs: got %0d want 1", hs_cnt - h0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (hs_cnt - h0 !== 1) begin errors++; $display("FAIL stall_single_hs: got %0d want 1", hs_cnt - h0); end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul;
    vec_t vm;
    int lat, busy;
    vm = '{2'b11, 3'b000, 1'b0, 64'h10001, 64'h10001, 64'h0000_0001_0002_0001, 4'b1111};
    out_ready = 1'b1;
    drive(vm);
    lat = 0; busy = 0;
    @(posedge clk); #1;
    lat = 1;
    in_valid = 1'b0;
    while (!out_valid && lat < 200) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy_in_ready: got %b want 0 at %0d", in_ready, lat); end
      busy++;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== XLEN + 1) begin errors++; $display("FAIL mul_latency: got %0d want %0d", lat, XLEN + 1); end
    checks++; if (busy !== XLEN) begin errors++; $display("FAIL mul_busy_cycles: got %0d want %0d", busy, XLEN); end
    checks++; if (result !== vm.res) begin errors++; $display("FAIL mul_result: got %h want %h", result, vm.res); end
    checks++; if (alu_ctrl !== 4'b1111) begin errors++; $display("FAIL mul_ctrl: got %b want 1111", alu_ctrl); end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_reset_abort;
    vec_t va;
    int h0, seen;
`ifdef ALU_MUL_EN
    va = '{2'b11, 3'b000, 1'b0, 64'd6, 64'd7, 64'd0, 4'b1111};
    out_ready = 1'b1;
`else
    va = '{2'b10, 3'b110, 1'b0, 64'd6, 64'd9, 64'd0, 4'b0110};
    out_ready = 1'b0;
`endif
    drive(va);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    h0 = hs_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL abort_result: got %h want 0", result); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready_rst: got %b want 0", in_ready); end
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready_rel: got %b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0 || hs_cnt !== h0) begin
      errors++; $display("FAIL abort_stale: valid cycles %0d handshakes %0d want 0 0", seen, hs_cnt - h0);
    end
  endtask

  initial begin
    test_reset;
    test_alu_ops;
    test_back_to_back;
    test_stall;
`ifdef ALU_MUL_EN
    test_mul;
`endif
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
